// File: rtl/dcs_sched_pkg.sv
// dcs_sched_pkg: shared definitions for the job scheduler.
// Holds the controller state encoding and the default job geometry
// (tokens per job, bytes per token, weight bytes, total job size).
package dcs_sched_pkg;

  localparam int N_TOK     = 8;
  localparam int TOK_DIM   = 16;
  localparam int N_W       = 8;
  localparam int IN_BYTES  = N_TOK * TOK_DIM;
  localparam int JOB_BYTES = IN_BYTES + N_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SEND_I,
    ST_WAIT_WR,
    ST_SEND_W,
    ST_DRAIN,
    ST_COOL
  } state_t;

endpackage

// File: rtl/dcs_job_sched_if.sv
// dcs_job_sched_if: bundle of requester, engine and result signals.
//   req/gnt/src_*     : two requesters sharing one job buffer
//   eng_i_* / eng_w_* : token and weight streams to the engine
//   eng_o_*           : result beats from the engine
//   res_*             : routed result, no backpressure
//   busy/err          : status (err only pulses with DCS_SCHED_TIMEOUT_EN)
// slave modport is the scheduler side, master is the environment side.
interface dcs_job_sched_if;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [1:0]  src_valid;
  logic [15:0] src_data;
  logic [1:0]  src_ready;
  logic        eng_i_valid;
  logic [7:0]  eng_i_data;
  logic        eng_w_valid;
  logic [7:0]  eng_w_data;
  logic        eng_w_ready;
  logic        eng_o_valid;
  logic [31:0] eng_o_data;
  logic        res_valid;
  logic        res_id;
  logic [31:0] res_data;
  logic        res_last;
  logic        busy;
  logic        err;

  modport slave (
    input  req, src_valid, src_data, eng_w_ready, eng_o_valid, eng_o_data,
    output gnt, src_ready, eng_i_valid, eng_i_data, eng_w_valid, eng_w_data,
    output res_valid, res_id, res_data, res_last, busy, err
  );

  modport master (
    output req, src_valid, src_data, eng_w_ready, eng_o_valid, eng_o_data,
    input  gnt, src_ready, eng_i_valid, eng_i_data, eng_w_valid, eng_w_data,
    input  res_valid, res_id, res_data, res_last, busy, err
  );
endinterface

// File: rtl/dcs_job_buf.sv
// dcs_job_buf: DEPTH x 8 job buffer with sequential write and read pointers.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (pointers only)
//   i_clr           : return both pointers to 0
//   i_wr_en/i_wr_data : write one byte at the write pointer
//   i_rd_en         : advance the read pointer
//   o_rd_data       : byte at the read pointer (combinational)
//   o_wptr/o_rptr   : current pointers
// Pointers saturate at DEPTH-1 so reads never index past the array.
module dcs_job_buf
  import dcs_sched_pkg::*;
#(
  parameter int DEPTH = JOB_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd_en,
  output logic [7:0] o_rd_data,
  output logic [7:0] o_wptr,
  output logic [7:0] o_rptr
);

  localparam logic [7:0] LAST = 8'(DEPTH - 1);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_wptr;
  logic [7:0] r_rptr;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_wr_en && r_wptr != LAST) r_wptr <= r_wptr + 8'd1;
      if (i_rd_en && r_rptr != LAST) r_rptr <= r_rptr + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_wptr    = r_wptr;
  assign o_rptr    = r_rptr;

endmodule

// File: rtl/dcs_job_sched.sv
// dcs_job_sched: two-requester job scheduler in front of a compute engine.
// A granted requester fills a 136-byte job (128 token bytes + 8 weight
// bytes); the tokens are streamed out, the weights follow one engine
// request later, and 8 result beats are routed back tagged with the
// requester index. Round-robin arbitration between jobs.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dcs_job_sched_if.slave (req/gnt, src_*, eng_*, res_*, busy, err)
// Optional build macro DCS_SCHED_TIMEOUT_EN: 8-bit watchdog over WAIT_WR and
// DRAIN that pulses err and forces COOL; without it err is tied to 0.
module dcs_job_sched #(
  parameter int N_TOK   = dcs_sched_pkg::N_TOK,
  parameter int TOK_DIM = dcs_sched_pkg::TOK_DIM,
  parameter int N_W     = dcs_sched_pkg::N_W
) (
  input  logic            clk,
  input  logic            rst,
  dcs_job_sched_if.slave  bus
);
  import dcs_sched_pkg::*;

  localparam int         IB        = N_TOK * TOK_DIM;
  localparam int         JB        = IB + N_W;
  localparam logic [7:0] LAST_IN   = 8'(IB - 1);
  localparam logic [7:0] LAST_BYTE = 8'(JB - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_gnt;
  logic        r_gnt_idx;
  logic        r_ptr;
  logic        r_cool;
  logic [2:0]  r_beat;
  logic        r_res_valid;
  logic        r_res_id;
  logic        r_res_last;
  logic [31:0] r_res_data;

  logic        w_pick;
  logic        w_accept;
  logic        w_beat;
  logic        w_rd_en;
  logic [1:0]  w_src_ready;
  logic [7:0]  w_src_byte;
  logic [7:0]  w_rd_data;
  logic [7:0]  w_wptr;
  logic [7:0]  w_rptr;

  // Requester pointed to wins a tie; otherwise whoever is asking.
  assign w_pick      = bus.req[r_ptr] ? r_ptr : ~r_ptr;
  assign w_src_ready = (r_state == ST_FILL) ? r_gnt : 2'b00;
  assign w_accept    = |(bus.src_valid & w_src_ready);
  assign w_src_byte  = r_gnt_idx ? bus.src_data[15:8] : bus.src_data[7:0];
  assign w_rd_en     = (r_state == ST_SEND_I) || (r_state == ST_SEND_W);
  assign w_beat      = (r_state == ST_DRAIN) && bus.eng_o_valid;

  dcs_job_buf #(.DEPTH(JB)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == ST_IDLE),
    .i_wr_en   (w_accept),
    .i_wr_data (w_src_byte),
    .i_rd_en   (w_rd_en),
    .o_rd_data (w_rd_data),
    .o_wptr    (w_wptr),
    .o_rptr    (w_rptr)
  );

`ifdef DCS_SCHED_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       w_wdog_hit;

  assign w_wdog_hit = ((r_state == ST_WAIT_WR) || (r_state == ST_DRAIN)) &&
                      (r_wdog == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) r_wdog <= '0;
    else if ((r_state == ST_WAIT_WR) || (r_state == ST_DRAIN)) r_wdog <= r_wdog + 8'd1;
    else r_wdog <= '0;
  end

  assign bus.err = w_wdog_hit;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (|bus.req) w_state_nxt = ST_FILL;
      ST_FILL:    if (w_accept && w_wptr == LAST_BYTE) w_state_nxt = ST_SEND_I;
      ST_SEND_I:  if (w_rptr == LAST_IN) w_state_nxt = ST_WAIT_WR;
      ST_WAIT_WR: if (bus.eng_w_ready) w_state_nxt = ST_SEND_W;
      ST_SEND_W:  if (w_rptr == LAST_BYTE) w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_beat && r_beat == 3'd7) w_state_nxt = ST_COOL;
      ST_COOL:    if (r_cool) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
`ifdef DCS_SCHED_TIMEOUT_EN
    if (w_wdog_hit) w_state_nxt = ST_COOL;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_gnt_idx   <= 1'b0;
      r_ptr       <= 1'b0;
      r_cool      <= 1'b0;
      r_beat      <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_last  <= 1'b0;
      r_res_data  <= '0;
    end else begin
      if (r_state == ST_IDLE && |bus.req) begin
        r_gnt     <= {w_pick, ~w_pick};
        r_gnt_idx <= w_pick;
      end
      if (r_state == ST_COOL && r_cool) begin
        r_gnt <= '0;
        r_ptr <= ~r_gnt_idx;
      end
      r_cool <= (r_state == ST_COOL) && !r_cool;
      if (r_state == ST_IDLE) r_beat <= '0;
      else if (w_beat)        r_beat <= r_beat + 3'd1;
      // result stage: one register between engine beat and routed result
      r_res_valid <= w_beat;
      r_res_id    <= w_beat & r_gnt_idx;
      r_res_last  <= w_beat && (r_beat == 3'd7);
      r_res_data  <= w_beat ? bus.eng_o_data : 32'd0;
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.src_ready   = w_src_ready;
  assign bus.eng_i_valid = (r_state == ST_SEND_I);
  assign bus.eng_i_data  = (r_state == ST_SEND_I) ? w_rd_data : 8'd0;
  assign bus.eng_w_valid = (r_state == ST_SEND_W);
  assign bus.eng_w_data  = (r_state == ST_SEND_W) ? w_rd_data : 8'd0;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_id      = r_res_id;
  assign bus.res_last    = r_res_last;
  assign bus.res_data    = r_res_data;
  assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dcs_job_sched.sv
// tb_dcs_job_sched: scenario bench for dcs_job_sched. Each job's bytes are
// kept in an array; the expected token/weight streams, grant order, result
// routing and cooldown timing are derived from that array and the job rules.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dcs_job_sched;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] job [136];

  dcs_job_sched_if ifc();

  dcs_job_sched u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ifc.req = 2'b00; ifc.src_valid = 2'b00; ifc.src_data = 16'd0;
    ifc.eng_w_ready = 1'b0; ifc.eng_o_valid = 1'b0; ifc.eng_o_data = 32'd0;
  endtask

  task automatic make_job(input bit incr);
    for (int i = 0; i < 136; i++) job[i] = incr ? 8'(i + 1) : 8'($urandom);
  endtask

  task automatic grant(input logic [1:0] mask, input int k);
    logic [1:0] want;
    want = (k == 0) ? 2'b01 : 2'b10;
    ifc.req = mask;
    @(negedge clk);
    total++;
    if (ifc.gnt !== want) begin bad++; $display("FAIL grant: got %b want %b", ifc.gnt, want); end
    total++;
    if (ifc.busy !== 1'b1) begin bad++; $display("FAIL busy_on_grant: got %b want 1", ifc.busy); end
  endtask

  task automatic fill(input int k, input bit gappy);
    int i = 0;
    int n = 0;
    logic [1:0] own;
    bit v;
    bit acc;
    own = (k == 0) ? 2'b01 : 2'b10;
    while (i < 136 && n < 2000) begin
      v = gappy ? ((n % 2) == 0) : 1'b1;
      ifc.src_valid = (2'($urandom) & ~own) | (v ? own : 2'b00);
      ifc.src_data  = 16'($urandom);
      if (k == 0) ifc.src_data[7:0] = job[i];
      else        ifc.src_data[15:8] = job[i];
      total++;
      if (ifc.src_ready !== own) begin
        bad++; $display("FAIL src_ready byte %0d: got %b want %b", i, ifc.src_ready, own);
      end
      acc = v && (ifc.src_ready[k] === 1'b1);
      @(negedge clk);
      if (acc) i++;
      n++;
    end
    ifc.src_valid = 2'b00;
    total++;
    if (i != 136) begin bad++; $display("FAIL fill_count: got %0d want 136", i); end
    total++;
    if (ifc.src_ready !== 2'b00) begin bad++; $display("FAIL src_ready_drop: got %b want 00", ifc.src_ready); end
  endtask

  task automatic send_i(input int rst_at, output bit aborted);
    int i = 0;
    aborted = 1'b0;
    while (ifc.eng_i_valid === 1'b1 && i < 200) begin
      total++;
      if (ifc.eng_i_data !== job[i]) begin
        bad++; $display("FAIL token %0d: got %h want %h", i, ifc.eng_i_data, job[i]);
      end
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        return;
      end
      i++;
      @(negedge clk);
    end
    total++;
    if (i != 128) begin bad++; $display("FAIL send_i_len: got %0d want 128", i); end
    total++;
    if (ifc.eng_i_data !== 8'd0) begin bad++; $display("FAIL eng_i_data_idle: got %h want 00", ifc.eng_i_data); end
  endtask

  task automatic weights(input int wait_cyc, input bit noise);
    int i = 0;
    for (int c = 0; c < wait_cyc; c++) begin
      ifc.eng_o_valid = noise ? 1'($urandom) : 1'b0;
      ifc.eng_o_data  = $urandom;
      @(negedge clk);
      total++;
      if ({ifc.eng_i_valid, ifc.eng_w_valid, ifc.res_valid, ifc.busy} !== 4'b0001) begin
        bad++; $display("FAIL wait_wr: got i/w/res/busy %b want 0001",
                        {ifc.eng_i_valid, ifc.eng_w_valid, ifc.res_valid, ifc.busy});
      end
    end
    ifc.eng_o_valid = 1'b0;
    ifc.eng_w_ready = 1'b1;
    total++;
    if (ifc.eng_w_valid !== 1'b0) begin bad++; $display("FAIL early_weight: got %b want 0", ifc.eng_w_valid); end
    @(negedge clk);
    ifc.eng_w_ready = 1'b0;
    while (ifc.eng_w_valid === 1'b1 && i < 20) begin
      total++;
      if (ifc.eng_w_data !== job[128 + i]) begin
        bad++; $display("FAIL weight %0d: got %h want %h", i, ifc.eng_w_data, job[128 + i]);
      end
      i++;
      @(negedge clk);
    end
    total++;
    if (i != 8) begin bad++; $display("FAIL send_w_len: got %0d want 8", i); end
    total++;
    if (ifc.eng_w_data !== 8'd0) begin bad++; $display("FAIL eng_w_data_idle: got %h want 00", ifc.eng_w_data); end
  endtask

  task automatic drain(input int k, input bit gappy, input logic [31:0] base);
    logic [1:0] own;
    own = (k == 0) ? 2'b01 : 2'b10;
    for (int j = 0; j < 8; j++) begin
      if (gappy) begin
        repeat ($urandom_range(0, 2)) begin
          ifc.eng_o_valid = 1'b0;
          @(negedge clk);
          total++;
          if (ifc.res_valid !== 1'b0) begin bad++; $display("FAIL res_gap: got %b want 0", ifc.res_valid); end
        end
      end
      ifc.eng_o_valid = 1'b1;
      ifc.eng_o_data  = 32'(base + j);
      @(negedge clk);
      ifc.eng_o_valid = 1'b0;
      ifc.eng_o_data  = 32'd0;
      total++;
      if ({ifc.res_valid, ifc.res_id, ifc.res_last, ifc.res_data} !==
          {1'b1, 1'(k), (j == 7), 32'(base + j)}) begin
        bad++; $display("FAIL result %0d: got v=%b id=%b last=%b d=%h want v=1 id=%0d last=%0d d=%h",
                        j, ifc.res_valid, ifc.res_id, ifc.res_last, ifc.res_data, k, (j == 7), 32'(base + j));
      end
    end
    total++;
    if ({ifc.busy, ifc.gnt, ifc.eng_i_valid, ifc.eng_w_valid} !== {1'b1, own, 2'b00}) begin
      bad++; $display("FAIL cool1: got busy/gnt/iv/wv %b want %b",
                      {ifc.busy, ifc.gnt, ifc.eng_i_valid, ifc.eng_w_valid}, {1'b1, own, 2'b00});
    end
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.res_valid} !== 2'b10) begin
      bad++; $display("FAIL cool2: got busy/res_valid %b want 10", {ifc.busy, ifc.res_valid});
    end
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.gnt} !== 3'b000) begin
      bad++; $display("FAIL back_to_idle: got busy/gnt %b want 000", {ifc.busy, ifc.gnt});
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({ifc.gnt, ifc.src_ready, ifc.busy, ifc.eng_i_valid, ifc.eng_w_valid,
         ifc.res_valid, ifc.res_id, ifc.res_last, ifc.err} !== 13'd0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {ifc.gnt, ifc.src_ready, ifc.busy,
                      ifc.eng_i_valid, ifc.eng_w_valid, ifc.res_valid, ifc.res_id, ifc.res_last, ifc.err});
    end
    total++;
    if ({ifc.eng_i_data, ifc.eng_w_data, ifc.res_data} !== 48'd0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {ifc.eng_i_data, ifc.eng_w_data, ifc.res_data});
    end
  endtask

  task automatic test_single();
    bit ab;
    make_job(1'b1);
    grant(2'b01, 0);
    ifc.req = 2'b00;
    fill(0, 1'b0);
    send_i(-1, ab);
    weights(3, 1'b1);
    drain(0, 1'b0, 32'h10);
  endtask

  task automatic test_reset_mid();
    bit ab;
    make_job(1'b0);
    grant(2'b01, 0);
    ifc.req = 2'b00;
    fill(0, 1'b0);
    send_i(60, ab);
    total++;
    if (ab !== 1'b1) begin bad++; $display("FAIL reset_mid_reached: got %b want 1", ab); end
    total++;
    if ({ifc.gnt, ifc.src_ready, ifc.busy, ifc.eng_i_valid, ifc.eng_w_valid, ifc.res_valid, ifc.err} !== 9'd0) begin
      bad++; $display("FAIL reset_mid_ctrl: got %b want 0", {ifc.gnt, ifc.src_ready, ifc.busy,
                      ifc.eng_i_valid, ifc.eng_w_valid, ifc.res_valid, ifc.err});
    end
    total++;
    if ({ifc.eng_i_data, ifc.eng_w_data, ifc.res_data} !== 48'd0) begin
      bad++; $display("FAIL reset_mid_data: got %h want 0", {ifc.eng_i_data, ifc.eng_w_data, ifc.res_data});
    end
    for (int c = 0; c < 4; c++) begin
      ifc.eng_o_valid = 1'b1;
      ifc.eng_o_data  = $urandom;
      @(negedge clk);
      total++;
      if ({ifc.res_valid, ifc.busy} !== 2'b00) begin
        bad++; $display("FAIL reset_mid_quiet: got res_valid/busy %b want 00", {ifc.res_valid, ifc.busy});
      end
    end
    ifc.eng_o_valid = 1'b0;
  endtask

  task automatic test_rr();
    bit ab;
    make_job(1'b0);
    grant(2'b11, 0);
    fill(0, 1'b0);
    send_i(-1, ab);
    weights(0, 1'b0);
    drain(0, 1'b0, 32'hA000_0000);
    make_job(1'b0);
    grant(2'b11, 1);
    ifc.req = 2'b00;
    fill(1, 1'b0);
    send_i(-1, ab);
    weights(1, 1'b0);
    drain(1, 1'b0, $urandom);
  endtask

  task automatic test_gaps();
    bit ab;
    make_job(1'b0);
    grant(2'b10, 1);
    ifc.req = 2'b00;
    fill(1, 1'b1);
    send_i(-1, ab);
    weights(2, 1'b1);
    drain(1, 1'b1, $urandom);
  endtask

  task automatic test_timeout();
    bit ab;
    int c = 0;
    make_job(1'b0);
    grant(2'b01, 0);
    ifc.req = 2'b00;
    fill(0, 1'b0);
    send_i(-1, ab);
`ifdef DCS_SCHED_TIMEOUT_EN
    while (ifc.err !== 1'b1 && c < 400) begin
      c++;
      @(negedge clk);
    end
    total++;
    if (c != 255) begin bad++; $display("FAIL timeout_cycles: got %0d want 255", c); end
    @(negedge clk);
    total++;
    if ({ifc.err, ifc.busy} !== 2'b01) begin bad++; $display("FAIL timeout_cool1: got err/busy %b want 01", {ifc.err, ifc.busy}); end
    @(negedge clk);
    total++;
    if ({ifc.err, ifc.busy} !== 2'b01) begin bad++; $display("FAIL timeout_cool2: got err/busy %b want 01", {ifc.err, ifc.busy}); end
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.gnt, ifc.res_valid} !== 4'b0000) begin
      bad++; $display("FAIL timeout_idle: got busy/gnt/res %b want 0000", {ifc.busy, ifc.gnt, ifc.res_valid});
    end
`else
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      total++;
      if ({ifc.err, ifc.busy, ifc.eng_w_valid} !== 3'b010) begin
        bad++; $display("FAIL no_watchdog cycle %0d: got err/busy/wv %b want 010", c,
                        {ifc.err, ifc.busy, ifc.eng_w_valid});
      end
    end
    weights(0, 1'b0);
    drain(0, 1'b0, 32'h5555_0000);
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_reset_mid();
    test_rr();
    test_gaps();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
